// File: rtl/alu_types.sv
// Shared ALU decode types: RV32I opcode/funct constants, ALU operation select,
// skid occupancy states and the decoded-operation record held in the skid buffer.
package alu_types;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_INVALID = 4'd0,
      ALU_AND     = 4'd1,
      ALU_OR      = 4'd2,
      ALU_XOR     = 4'd3,
      ALU_SLL     = 4'd5,
      ALU_SRL     = 4'd6,
      ALU_SRA     = 4'd7,
      ALU_ADD     = 4'd8,
      ALU_SUB     = 4'd9,
      ALU_SLT     = 4'd10,
      ALU_SLTU    = 4'd11
   } alu_control_t;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_state_t;

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      alu_control_t    control;
      logic [4:0]      rd;
      logic            illegal;
   } alu_op_t;

   localparam alu_op_t ALU_OP_RESET = '{a: '0, b: '0, control: ALU_INVALID, rd: '0, illegal: 1'b0};

   // Base mapping of funct3 when funct7/imm[11:5] selects the non-alternate form.
   function automatic alu_control_t f3_to_control(input logic [2:0] f3);
      alu_control_t ctl;
      case (f3)
         F3_ADD_SUB: ctl = ALU_ADD;
         F3_SLL:     ctl = ALU_SLL;
         F3_SLT:     ctl = ALU_SLT;
         F3_SLTU:    ctl = ALU_SLTU;
         F3_XOR:     ctl = ALU_XOR;
         F3_SRL_SRA: ctl = ALU_SRL;
         F3_OR:      ctl = ALU_OR;
         default:    ctl = ALU_AND;
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I OP / OP-IMM decode into ALU operands, operation select and rd.
// Anything that is not a legal ALU instruction is flagged illegal with zeroed operands.
module alu_decode
   import alu_types::*;
(
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic [XLEN-1:0] a,
   output logic [XLEN-1:0] b,
   output alu_control_t    control,
   output logic [4:0]      rd,
   output logic            illegal
);

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_sext;
   logic [XLEN-1:0] shamt_zext;
   logic [XLEN-1:0] b_raw;
   alu_control_t    ctl;
   logic            unused_rs1_idx;

   assign opcode     = instr[6:0];
   assign f3         = instr[14:12];
   assign f7         = instr[31:25];
   assign imm_sext   = {{20{instr[31]}}, instr[31:20]};
   assign shamt_zext = {27'd0, instr[24:20]};
   assign unused_rs1_idx = ^instr[19:15];

   always_comb begin
      ctl   = ALU_INVALID;
      b_raw = '0;
      case (opcode)
         OPC_OP: begin
            b_raw = rs2_val;
            if (f7 == F7_BASE) begin
               ctl = f3_to_control(f3);
            end else if (f7 == F7_ALT && f3 == F3_ADD_SUB) begin
               ctl = ALU_SUB;
            end else if (f7 == F7_ALT && f3 == F3_SRL_SRA) begin
               ctl = ALU_SRA;
            end
         end
         OPC_OP_IMM: begin
            b_raw = imm_sext;
            // Shifts reuse imm[11:5] as a funct7 and take only the 5-bit shamt.
            if (f3 == F3_SLL) begin
               b_raw = shamt_zext;
               if (f7 == F7_BASE) ctl = ALU_SLL;
            end else if (f3 == F3_SRL_SRA) begin
               b_raw = shamt_zext;
               if (f7 == F7_BASE)     ctl = ALU_SRL;
               else if (f7 == F7_ALT) ctl = ALU_SRA;
            end else begin
               ctl = f3_to_control(f3);
            end
         end
         default: ctl = ALU_INVALID;
      endcase
   end

   assign control = ctl;
   assign illegal = (ctl == ALU_INVALID);
   assign a       = illegal ? '0 : rs1_val;
   assign b       = illegal ? '0 : b_raw;
   assign rd      = instr[11:7];

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an instruction and holds it in a 2-entry skid buffer.
// Handshake: a side transfers only in a cycle where its valid and ready are both high.
module alu_issue
   import alu_types::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_instr,
   input  logic [N-1:0] in_rs1_val,
   input  logic [N-1:0] in_rs2_val,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_a,
   output logic [N-1:0] out_b,
   output alu_control_t out_control,
   output logic [4:0]   out_rd,
   output logic         out_illegal,
   output skid_state_t  dbg_state
);

   skid_state_t state_q, state_d;
   alu_op_t     head_q, head_d;
   alu_op_t     tail_q, tail_d;
   logic        in_ready_q, in_ready_d;
   alu_op_t     dec;
   logic        accept;
   logic        deq;

   alu_decode u_decode (
      .instr   (in_instr),
      .rs1_val (in_rs1_val),
      .rs2_val (in_rs2_val),
      .a       (dec.a),
      .b       (dec.b),
      .control (dec.control),
      .rd      (dec.rd),
      .illegal (dec.illegal)
   );

   assign accept = in_valid && in_ready_q;
   assign deq    = (state_q != SKID_EMPTY) && out_ready;

   // Head always holds the oldest entry; tail is only occupied in TWO.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         SKID_EMPTY: begin
            if (accept) begin
               head_d  = dec;
               state_d = SKID_ONE;
            end
         end
         SKID_ONE: begin
            if (accept && deq) begin
               head_d = dec;
            end else if (accept) begin
               tail_d  = dec;
               state_d = SKID_TWO;
            end else if (deq) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_TWO: begin
            if (deq) begin
               head_d  = tail_q;
               state_d = SKID_ONE;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
      in_ready_d = (state_d != SKID_TWO);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= SKID_EMPTY;
         head_q     <= ALU_OP_RESET;
         tail_q     <= ALU_OP_RESET;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = (state_q != SKID_EMPTY);
   assign out_a       = head_q.a;
   assign out_b       = head_q.b;
   assign out_control = head_q.control;
   assign out_rd      = head_q.rd;
   assign out_illegal = head_q.illegal;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed-vector bench for alu_issue: decode results, skid backpressure ordering,
// and reset behaviour while the buffer is full.
module tb_alu_issue;
   import alu_types::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_instr;
   logic [31:0]  in_rs1_val;
   logic [31:0]  in_rs2_val;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_a;
   logic [31:0]  out_b;
   alu_control_t out_control;
   logic [4:0]   out_rd;
   logic         out_illegal;
   skid_state_t  dbg_state;

   int checks_total  = 0;
   int checks_passed = 0;

   logic [31:0] exp_q[$];
   logic [31:0] bp_instr[3];
   logic [31:0] bp_rs1[3];
   int          idx;
   int          drained;
   logic        acc;

   alu_issue #(.N(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_rs1_val  (in_rs1_val),
      .in_rs2_val  (in_rs2_val),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_control (out_control),
      .out_rd      (out_rd),
      .out_illegal (out_illegal),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks_total++;
      if (obs !== expv) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
      else checks_passed++;
   endtask

   // Called at a negedge; offers one instruction, then checks it one cycle later.
   task automatic run_vec(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                          input logic [31:0] rs2, input alu_control_t ectl, input logic [31:0] ea,
                          input logic [31:0] eb, input logic [4:0] erd, input logic eill);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid   = 1'b1;
      in_instr   = instr;
      in_rs1_val = rs1;
      in_rs2_val = rs2;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_ctl"}, 32'(out_control), 32'(ectl));
      check({tag, "_a"}, out_a, ea);
      check({tag, "_b"}, out_b, eb);
      check({tag, "_rd"}, 32'(out_rd), 32'(erd));
      check({tag, "_ill"}, 32'(out_illegal), 32'(eill));
      @(negedge clk);
   endtask

   initial begin
      rst        = 1'b0;
      in_valid   = 1'b0;
      in_instr   = '0;
      in_rs1_val = '0;
      in_rs2_val = '0;
      out_ready  = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_a", out_a, 32'd0);
      check("rst_out_b", out_b, 32'd0);
      check("rst_ctl", 32'(out_control), 32'(ALU_INVALID));
      check("rst_rd", 32'(out_rd), 32'd0);
      check("rst_ill", 32'(out_illegal), 32'd0);
      repeat (2) @(negedge clk);
      check("rst_held_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_release_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      run_vec("addi_m1", 32'hFFF00093, 32'd0, 32'd7, ALU_ADD, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b0);
      run_vec("sub", 32'h402081B3, 32'd10, 32'd3, ALU_SUB, 32'd10, 32'd3, 5'd3, 1'b0);
      run_vec("srai", 32'h40435293, 32'h80000000, 32'd9, ALU_SRA, 32'h80000000, 32'd4, 5'd5, 1'b0);
      run_vec("slli_alt", {7'b0100000, 5'd3, 5'd6, 3'b001, 5'd5, 7'b0010011}, 32'h1234, 32'd1,
              ALU_INVALID, 32'd0, 32'd0, 5'd5, 1'b1);
      run_vec("opc_7f", 32'h000000FF, 32'd5, 32'd6, ALU_INVALID, 32'd0, 32'd0, 5'd1, 1'b1);
      run_vec("and", {7'b0000000, 5'd2, 5'd1, 3'b111, 5'd7, 7'b0110011}, 32'hF0F0F0F0, 32'h0FF00FF0,
              ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd7, 1'b0);
      run_vec("op_f7_bad", {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd4, 7'b0110011}, 32'd11, 32'd12,
              ALU_INVALID, 32'd0, 32'd0, 5'd4, 1'b1);
      run_vec("sltiu_neg", {12'h800, 5'd1, 3'b011, 5'd9, 7'b0010011}, 32'd20, 32'd0,
              ALU_SLTU, 32'd20, 32'hFFFFF800, 5'd9, 1'b0);
      run_vec("slli_31", {7'b0000000, 5'd31, 5'd3, 3'b001, 5'd2, 7'b0010011}, 32'd1, 32'd0,
              ALU_SLL, 32'd1, 32'd31, 5'd2, 1'b0);
      run_vec("srl", {7'b0000000, 5'd2, 5'd1, 3'b101, 5'd8, 7'b0110011}, 32'hABCD0000, 32'd16,
              ALU_SRL, 32'hABCD0000, 32'd16, 5'd8, 1'b0);
      run_vec("xori_pos", {12'h7FF, 5'd1, 3'b100, 5'd10, 7'b0010011}, 32'h55, 32'd0,
              ALU_XOR, 32'h55, 32'h000007FF, 5'd10, 1'b0);
      run_vec("slt_alt", {7'b0100000, 5'd2, 5'd1, 3'b010, 5'd6, 7'b0110011}, 32'd1, 32'd2,
              ALU_INVALID, 32'd0, 32'd0, 5'd6, 1'b1);

      @(posedge clk);
      @(negedge clk);
      check("idle_out_valid", 32'(out_valid), 32'd0);

      // Backpressure: three distinct instructions held against a stalled output.
      bp_instr[0] = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd11, 7'b0110011};
      bp_instr[1] = {7'b0000000, 5'd2, 5'd1, 3'b110, 5'd12, 7'b0110011};
      bp_instr[2] = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd13, 7'b0110011};
      bp_rs1[0] = 32'h111;
      bp_rs1[1] = 32'h222;
      bp_rs1[2] = 32'h333;
      exp_q.delete();
      idx        = 0;
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      in_instr   = bp_instr[0];
      in_rs1_val = bp_rs1[0];
      in_rs2_val = 32'd1;
      for (int c = 0; c < 4; c++) begin
         acc = in_valid && in_ready;
         @(posedge clk);
         if (acc) begin
            exp_q.push_back(bp_rs1[idx]);
            idx++;
         end
         @(negedge clk);
         if (idx < 3) begin
            in_instr   = bp_instr[idx];
            in_rs1_val = bp_rs1[idx];
         end else begin
            in_valid = 1'b0;
         end
      end
      check("bp_accepted", 32'(idx), 32'd2);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_head_a", out_a, 32'h111);
      check("bp_head_rd", 32'(out_rd), 32'd11);
      check("bp_state", 32'(dbg_state), 32'(SKID_TWO));

      out_ready = 1'b1;
      drained   = 0;
      for (int c = 0; c < 20 && !(idx == 3 && exp_q.size() == 0); c++) begin
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("drain_extra", 32'd1, 32'd0);
            else check("drain_a", out_a, exp_q.pop_front());
            drained++;
         end
         @(posedge clk);
         if (acc) begin
            exp_q.push_back(bp_rs1[idx]);
            idx++;
         end
         @(negedge clk);
         if (idx < 3) begin
            in_instr   = bp_instr[idx];
            in_rs1_val = bp_rs1[idx];
         end else begin
            in_valid = 1'b0;
         end
      end
      check("drain_count", 32'(drained), 32'd3);
      check("drain_accepted", 32'(idx), 32'd3);
      check("drain_q_empty", 32'(exp_q.size()), 32'd0);
      check("drain_out_valid", 32'(out_valid), 32'd0);

      // Fill to TWO, then reset mid-flight.
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      in_instr   = 32'hFFF00093;
      in_rs1_val = 32'hDEAD;
      @(posedge clk);
      @(negedge clk);
      in_instr   = 32'h402081B3;
      in_rs1_val = 32'hBEEF;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("full_state", 32'(dbg_state), 32'(SKID_TWO));
      check("full_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_a", out_a, 32'd0);
      check("mid_rst_ctl", 32'(out_control), 32'(ALU_INVALID));
      check("mid_rst_rd", 32'(out_rd), 32'd0);
      check("mid_rst_state", 32'(dbg_state), 32'(SKID_EMPTY));
      @(negedge clk);
      rst       = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      repeat (2) begin
         @(negedge clk);
         check("post_rst_no_stale", 32'(out_valid), 32'd0);
      end
      run_vec("post_rst_addi", 32'hFFF00093, 32'd3, 32'd0, ALU_ADD, 32'd3, 32'hFFFFFFFF, 5'd1, 1'b0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter N, default 32, datapath width; only N=32 is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream offers an instruction and operands.
REQ-005 in_ready  output  1  block can accept this cycle.
REQ-006 in_instr  input  32  RV32I instruction word.
REQ-007 in_rs1_val  input  N  rs1 register value.
REQ-008 in_rs2_val  input  N  rs2 register value.
REQ-009 out_valid  output  1  decoded ALU operation available.
REQ-010 out_ready  input  1  downstream ALU stage accepts.
REQ-011 out_a  output  N  ALU operand a.
REQ-012 out_b  output  N  ALU operand b.
REQ-013 out_control  output  alu_control_t  ALU operation select.
REQ-014 out_rd  output  5  destination register index.
REQ-015 out_illegal  output  1  instruction is not a decodable OP/OP-IMM ALU instruction.

Function
REQ-016 Transfers SHALL occur on a side only in cycles where valid and ready are both high.
REQ-017 An accepted instruction SHALL first appear on the outputs in the cycle after acceptance (1-cycle latency).
REQ-018 Buffering SHALL be a 2-entry skid; occupancy state: EMPTY, ONE, TWO.
REQ-019 in_ready SHALL be high iff state is not TWO, registered, not combinationally dependent on out_ready.
REQ-020 Transitions: accept-only -> +1; output-transfer-only -> -1; both in the same cycle -> unchanged; out_valid high iff state is not EMPTY.
REQ-021 Output SHALL present the oldest entry; entries leave in acceptance order, none dropped or duplicated.
REQ-022 While out_valid is high and out_ready is low, all out_* SHALL hold stable.
REQ-023 Opcode 0110011 (OP): out_b = rs2_val; funct3 000 -> ADD (funct7 0000000) or SUB (funct7 0100000); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL (0000000) or SRA (0100000); 110 OR; 111 AND; any other funct7 -> illegal.
REQ-024 Opcode 0010011 (OP-IMM): out_b = sign-extended instr[31:20]; same funct3 map without SUB; funct3 001 requires imm[11:5]=0000000 (SLL); funct3 101 requires imm[11:5]=0000000 (SRL) or 0100000 (SRA); shifts: out_b = zero-extended instr[24:20].
REQ-025 out_a SHALL equal rs1_val; out_rd SHALL equal instr[11:7] for every entry.
REQ-026 Illegal instructions SHALL still be accepted and forwarded, with out_illegal=1, out_control=ALU_INVALID, out_a=out_b=0.
REQ-027 No arithmetic wraps in decode; sign extension from bit 31 of the instruction only.

Reset
REQ-028 rst low SHALL immediately force state EMPTY, out_valid=0, in_ready=0, out_a=out_b=0, out_control=ALU_INVALID, out_rd=0, out_illegal=0.
REQ-029 In-flight entries SHALL be discarded on reset; in_ready SHALL rise on the first clk edge after rst deasserts.

Structure
REQ-030 alu_control_t (ALU_INVALID=0, AND=1, OR=2, XOR=3, SLL=5, SRL=6, SRA=7, ADD, SUB, SLT, SLTU), plus the opcode and funct constants, SHALL live in the shared alu_types package.
REQ-031 Decode SHALL be a combinational sub-module alu_decode (instr and operands in; a, b, control, rd, illegal out) feeding the skid storage.

Verification
REQ-032 addi x1,x0,-1 (0xFFF00093), rs1_val=0, out_ready=1 -> next cycle out_control=ADD, out_b=0xFFFFFFFF, out_rd=1, out_illegal=0.
REQ-033 sub x3,x1,x2 (0x402081B3), rs1=10, rs2=3 -> out_control=SUB, out_a=10, out_b=3, out_rd=3.
REQ-034 srai x5,x6,4 (0x40435293) -> out_control=SRA, out_b=4; slli with imm[11:5]=0100000 -> out_illegal=1, out_control=ALU_INVALID.
REQ-035 in_valid held with three distinct instructions, out_ready=0 for 4 cycles -> two accepted, in_ready low; out_ready=1 -> drains in order, third accepted, no loss.
REQ-036 Opcode 0x7F instruction -> forwarded with out_illegal=1, a=b=0.
REQ-037 rst asserted while state TWO -> out_valid=0 immediately; after release in_ready=1 next edge and no stale entries appear.
